// File: rtl/nxu8_sio_master.sv
// nX-U8 debug-port serial master: serialises one register access onto the clock/data pins.
// Optional even-parity slots are compiled in by defining NXU8_SIO_PARITY_EN.
module nxu8_sio_master #(
  parameter int unsigned NX_CLK_DIV = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [6:0]  i_addr,
  input  logic [15:0] i_data,
  input  logic        i_wr,
  output logic [15:0] o_data,
  output logic        o_busy,
  output logic        o_perr,
  output logic        o_nx_clk,
  inout  wire         io_nx_data
);

`ifdef NXU8_SIO_PARITY_EN
  localparam logic ParEn = 1'b1;
`else
  localparam logic ParEn = 1'b0;
`endif
  localparam logic [7:0] PhaseLast = 8'(NX_CLK_DIV - 1);

  if (NX_CLK_DIV < 2 || NX_CLK_DIV > 255) begin : g_div_check
    $error("NX_CLK_DIV must be within 2..255");
  end

  typedef enum logic [2:0] {
    StIdle, StHdr, StWdata, StTurn, StRdata, StParTx, StParRx, StStop
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic        nx_clk_q, nx_clk_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [23:0] tx_sr_q, tx_sr_d;
  logic [15:0] rx_sr_q, rx_sr_d;
  logic [15:0] data_q, data_d;
  logic        wr_q, wr_d;
  logic [1:0]  sync_q;
  logic        half_end, slot_end, rx_load;
  logic        tx_par, drive_en, drive_bit;
  logic [15:0] rx_word;

  assign half_end = (phase_q == PhaseLast);
  // A slot ends on the last cycle of its high half.
  assign slot_end = half_end && nx_clk_q && (state_q != StIdle);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:           if (i_start) state_d = StHdr;
      StHdr:            if (slot_end && bit_cnt_q == 5'd7) state_d = wr_q ? StWdata : StTurn;
      StWdata:          if (slot_end && bit_cnt_q == 5'd15) state_d = ParEn ? StParTx : StStop;
      StTurn:           if (slot_end) state_d = StRdata;
      StRdata:          if (slot_end && bit_cnt_q == 5'd15) state_d = ParEn ? StParRx : StStop;
      StParTx, StParRx: if (slot_end) state_d = StStop;
      StStop:           if (slot_end) state_d = StIdle;
      default:          state_d = StIdle;
    endcase
  end

  always_comb begin
    o_busy    = (state_q != StIdle);
    drive_en  = (state_q == StHdr) || (state_q == StWdata) || (state_q == StParTx);
    drive_bit = (state_q == StParTx) ? tx_par : tx_sr_q[23];
  end

  assign io_nx_data = drive_en ? drive_bit : 1'bz;
  assign o_nx_clk   = nx_clk_q;
  assign o_data     = data_q;

  // The final data bit is still in the synchroniser when RDATA ends, so merge it in.
  assign rx_word = (state_q == StRdata) ? {rx_sr_q[14:0], sync_q[1]} : rx_sr_q;
  assign rx_load = slot_end && ((state_q == StRdata && !ParEn) || state_q == StParRx);

  always_comb begin
    phase_d   = phase_q;
    nx_clk_d  = nx_clk_q;
    bit_cnt_d = bit_cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    wr_d      = wr_q;
    data_d    = data_q;
    if (state_q == StIdle) begin
      phase_d   = '0;
      bit_cnt_d = '0;
      nx_clk_d  = 1'b1;
      if (i_start) begin
        nx_clk_d = 1'b0;
        tx_sr_d  = {i_wr, i_addr, i_data};
        wr_d     = i_wr;
      end
    end else if (!half_end) begin
      phase_d = phase_q + 8'd1;
    end else begin
      phase_d  = '0;
      nx_clk_d = ~nx_clk_q;
      if (nx_clk_q) begin
        bit_cnt_d = (state_d == state_q) ? bit_cnt_q + 5'd1 : 5'd0;
        tx_sr_d   = {tx_sr_q[22:0], 1'b0};
        if (state_q == StRdata) rx_sr_d = rx_word;
        if (rx_load) data_d = rx_word;
        // Leaving STOP: hold the clock high rather than starting another low half.
        if (state_d == StIdle) nx_clk_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_q   <= '0;
      nx_clk_q  <= 1'b1;
      bit_cnt_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      sync_q    <= '0;
    end else begin
      phase_q   <= phase_d;
      nx_clk_q  <= nx_clk_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      sync_q    <= {sync_q[0], io_nx_data};
    end
  end

`ifdef NXU8_SIO_PARITY_EN
  logic tx_par_q, hdr_par_q, perr_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_par_q  <= 1'b0;
      hdr_par_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      if (state_q == StIdle && i_start) begin
        tx_par_q  <= ^{i_wr, i_addr, i_data};
        hdr_par_q <= ^{i_wr, i_addr};
      end
      if (rx_load) perr_q <= hdr_par_q ^ (^rx_sr_q) ^ sync_q[1];
    end
  end

  assign tx_par = tx_par_q;
  assign o_perr = perr_q;
`else
  assign tx_par = 1'b0;
  assign o_perr = 1'b0;
`endif

endmodule

// File: tb/tb_nxu8_sio_master.sv
// Self-checking bench for nxu8_sio_master with a slot-level target model on the serial pins.
module tb_nxu8_sio_master;
  localparam int unsigned Div = 10;
`ifdef NXU8_SIO_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif

  logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, wr = 1'b0;
  logic [6:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata_o;
  logic        busy, perr, nx_clk;
  wire         nx_data;
  logic        tgt_oe = 1'b1, tgt_bit = 1'b0;

  int vectors = 0, errors = 0;

  always #5 clk = ~clk;
  assign nx_data = tgt_oe ? tgt_bit : 1'bz;

  nxu8_sio_master #(.NX_CLK_DIV(Div)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_addr(addr), .i_data(wdata), .i_wr(wr),
    .o_data(rdata_o), .o_busy(busy), .o_perr(perr), .o_nx_clk(nx_clk), .io_nx_data(nx_data)
  );

  // Target model: slot k (1-based) starts on each falling edge of the serial clock.
  int          frame_no = 0, seen_frame = 0, k = 0;
  logic        t_wr = 1'b0, t_flip = 1'b0;
  logic [6:0]  t_addr = '0;
  logic [15:0] t_rdata = '0;

  always @(negedge nx_clk) begin
    if (seen_frame != frame_no) begin
      seen_frame = frame_no;
      k = 0;
    end
    k = k + 1;
    if (k <= 8 || (t_wr && k <= 24 + Par)) begin
      tgt_oe = 1'b0;
    end else begin
      tgt_oe = 1'b1;
      if (!t_wr && k >= 10 && k <= 25) tgt_bit = t_rdata[25-k];
      else if (!t_wr && Par == 1 && k == 26) tgt_bit = (^{1'b0, t_addr, t_rdata}) ^ t_flip;
      else tgt_bit = 1'($urandom);
    end
  end

  logic smp_q[$];
  logic smp_tb_q[$];
  always @(posedge nx_clk) begin
    smp_q.push_back(nx_data);
    smp_tb_q.push_back(tgt_bit);
  end

  int          busy_cnt, nsmp;
  logic        timed_out, busy_after, aborted;
  logic [31:0] obs_v, tbv;
  logic [15:0] exp_data = '0;
  logic        exp_perr = 1'b0;

  function automatic int exp_slots(input logic w);
    return (w ? 25 : 26) + Par;
  endfunction

  function automatic int exp_busy(input logic w);
    return exp_slots(w) * 2 * int'(Div);
  endfunction

  // Expected line value per rising edge: master bits where it owns the line, target's bit elsewhere.
  function automatic logic [31:0] exp_stream(input logic w, input logic [6:0] a,
                                             input logic [15:0] d, input logic [31:0] tb_bits);
    logic [23:0] m;
    logic [31:0] s;
    int nm;
    m  = {w, a, d};
    nm = w ? 24 : 8;
    s  = tb_bits;
    for (int i = 0; i < nm; i++) s[i] = m[23-i];
    if (w && Par == 1) s[24] = ^m;
    for (int i = exp_slots(w); i < 32; i++) s[i] = 1'b0;
    return s;
  endfunction

  task automatic do_frame(input logic w, input logic [6:0] a, input logic [15:0] d,
                          input logic [15:0] rd, input logic flip, input logic inj_mid,
                          input logic inj_end, input int abort_slot);
    int n;
    n = exp_busy(w);
    @(negedge clk);
    t_wr = w; t_addr = a; t_rdata = rd; t_flip = flip;
    frame_no++;
    smp_q.delete(); smp_tb_q.delete();
    wr = w; addr = a; wdata = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0; wr = ~w; addr = a ^ 7'h55; wdata = ~d;
    busy_cnt = 0; aborted = 1'b0;
    for (int c = 0; c < 4000 && busy; c++) begin
      if (abort_slot != 0 && seen_frame == frame_no && k == abort_slot) begin
        rst_n = 1'b0;
        aborted = 1'b1;
        break;
      end
      busy_cnt++;
      start = (inj_mid && busy_cnt == 100) || (inj_end && busy_cnt == n);
      @(negedge clk);
    end
    timed_out = !aborted && busy;
    start = 1'b0;
    busy_after = 1'b0;
    if (!aborted) begin
      repeat (3) begin
        @(negedge clk);
        busy_after = busy_after | busy;
      end
      nsmp = smp_q.size();
      obs_v = '0; tbv = '0;
      for (int i = 0; i < nsmp && i < 32; i++) begin
        obs_v[i] = smp_q[i];
        tbv[i]   = smp_tb_q[i];
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (nx_clk !== 1'b1) begin errors++; $display("FAIL reset_nx_clk got %b want 1", nx_clk); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (rdata_o !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", rdata_o); end
    vectors++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", perr); end
    vectors++; if (nx_data !== tgt_bit) begin errors++; $display("FAIL reset_line got %b want %b (released)", nx_data, tgt_bit); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    do_frame(1'b1, 7'h12, 16'hA55A, 16'h0, 1'b0, 1'b0, 1'b0, 0);
    vectors++; if (timed_out || busy_cnt != exp_busy(1'b1)) begin errors++; $display("FAIL write_busy got %0d want %0d", busy_cnt, exp_busy(1'b1)); end
    vectors++; if (nsmp != exp_slots(1'b1) || obs_v !== exp_stream(1'b1, 7'h12, 16'hA55A, tbv)) begin errors++; $display("FAIL write_stream got %h/%0d want %h/%0d", obs_v, nsmp, exp_stream(1'b1, 7'h12, 16'hA55A, tbv), exp_slots(1'b1)); end
    vectors++; if (rdata_o !== exp_data || perr !== exp_perr) begin errors++; $display("FAIL write_data got %h/%b want %h/%b", rdata_o, perr, exp_data, exp_perr); end
  endtask

  task automatic test_read();
    do_frame(1'b0, 7'h05, 16'h0, 16'h1234, 1'b0, 1'b0, 1'b0, 0);
    exp_data = 16'h1234; exp_perr = 1'b0;
    vectors++; if (timed_out || busy_cnt != exp_busy(1'b0)) begin errors++; $display("FAIL read_busy got %0d want %0d", busy_cnt, exp_busy(1'b0)); end
    vectors++; if (nsmp != exp_slots(1'b0) || obs_v !== exp_stream(1'b0, 7'h05, 16'h0, tbv)) begin errors++; $display("FAIL read_stream got %h/%0d want %h/%0d", obs_v, nsmp, exp_stream(1'b0, 7'h05, 16'h0, tbv), exp_slots(1'b0)); end
    vectors++; if (rdata_o !== exp_data || perr !== exp_perr) begin errors++; $display("FAIL read_data got %h/%b want %h/%b", rdata_o, perr, exp_data, exp_perr); end
  endtask

  task automatic test_ignore_start();
    logic [6:0] a;
    logic [15:0] rd;
    a = 7'($urandom); rd = 16'($urandom);
    do_frame(1'b0, a, 16'h0, rd, 1'b0, 1'b1, 1'b1, 0);
    exp_data = rd; exp_perr = 1'b0;
    vectors++; if (timed_out || busy_cnt != exp_busy(1'b0)) begin errors++; $display("FAIL ignore_busy got %0d want %0d", busy_cnt, exp_busy(1'b0)); end
    vectors++; if (busy_after !== 1'b0) begin errors++; $display("FAIL ignore_reaccept got busy=%b want 0", busy_after); end
    vectors++; if (nsmp != exp_slots(1'b0) || obs_v !== exp_stream(1'b0, a, 16'h0, tbv)) begin errors++; $display("FAIL ignore_stream got %h/%0d want %h/%0d", obs_v, nsmp, exp_stream(1'b0, a, 16'h0, tbv), exp_slots(1'b0)); end
    vectors++; if (rdata_o !== exp_data) begin errors++; $display("FAIL ignore_data got %h want %h", rdata_o, exp_data); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd;
    rd = 16'($urandom);
    do_frame(1'b0, 7'h33, 16'h0, 16'h5A5A, 1'b0, 1'b0, 1'b0, 10);
    #1;
    exp_data = 16'h0000; exp_perr = 1'b0;
    vectors++; if (!aborted) begin errors++; $display("FAIL abort_reached got %b want 1", aborted); end
    vectors++; if (nx_clk !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_clk_busy got %b/%b want 1/0", nx_clk, busy); end
    vectors++; if (rdata_o !== exp_data || perr !== exp_perr) begin errors++; $display("FAIL abort_data got %h/%b want 0000/0", rdata_o, perr); end
    vectors++; if (nx_data !== tgt_bit) begin errors++; $display("FAIL abort_line got %b want %b (released)", nx_data, tgt_bit); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_frame(1'b0, 7'h33, 16'h0, rd, 1'b0, 1'b0, 1'b0, 0);
    exp_data = rd;
    vectors++; if (timed_out || busy_cnt != exp_busy(1'b0)) begin errors++; $display("FAIL post_abort_busy got %0d want %0d", busy_cnt, exp_busy(1'b0)); end
    vectors++; if (nsmp != exp_slots(1'b0) || obs_v !== exp_stream(1'b0, 7'h33, 16'h0, tbv)) begin errors++; $display("FAIL post_abort_stream got %h/%0d want %h", obs_v, nsmp, exp_stream(1'b0, 7'h33, 16'h0, tbv)); end
    vectors++; if (rdata_o !== exp_data) begin errors++; $display("FAIL post_abort_data got %h want %h", rdata_o, exp_data); end
  endtask

  task automatic test_back_to_back();
    logic        w_t [3] = '{1'b0, 1'b1, 1'b0};
    logic [6:0]  a_t [3] = '{7'h01, 7'h02, 7'h01};
    logic [15:0] d_t [3] = '{16'h0000, 16'h0001, 16'h0000};
    logic [15:0] r_t [3] = '{16'hBEEF, 16'h0000, 16'hCAFE};
    for (int i = 0; i < 3; i++) begin
      do_frame(w_t[i], a_t[i], d_t[i], r_t[i], 1'b0, 1'b0, 1'b0, 0);
      if (!w_t[i]) begin exp_data = r_t[i]; exp_perr = 1'b0; end
      vectors++; if (timed_out || busy_cnt != exp_busy(w_t[i])) begin errors++; $display("FAIL b2b%0d_busy got %0d want %0d", i, busy_cnt, exp_busy(w_t[i])); end
      vectors++; if (nsmp != exp_slots(w_t[i]) || obs_v !== exp_stream(w_t[i], a_t[i], d_t[i], tbv)) begin errors++; $display("FAIL b2b%0d_stream got %h/%0d want %h", i, obs_v, nsmp, exp_stream(w_t[i], a_t[i], d_t[i], tbv)); end
      vectors++; if (rdata_o !== exp_data) begin errors++; $display("FAIL b2b%0d_data got %h want %h", i, rdata_o, exp_data); end
    end
  endtask

  task automatic test_random();
    logic w, flip;
    logic [6:0] a;
    logic [15:0] d, rd;
    for (int i = 0; i < 6; i++) begin
      w = 1'($urandom); a = 7'($urandom); d = 16'($urandom); rd = 16'($urandom);
      flip = (Par == 1) ? 1'($urandom) : 1'b0;
      do_frame(w, a, d, rd, flip, 1'b0, 1'b0, 0);
      if (!w) begin exp_data = rd; exp_perr = flip; end
      vectors++; if (timed_out || busy_cnt != exp_busy(w)) begin errors++; $display("FAIL rnd%0d_busy got %0d want %0d", i, busy_cnt, exp_busy(w)); end
      vectors++; if (nsmp != exp_slots(w) || obs_v !== exp_stream(w, a, d, tbv)) begin errors++; $display("FAIL rnd%0d_stream got %h/%0d want %h", i, obs_v, nsmp, exp_stream(w, a, d, tbv)); end
      vectors++; if (rdata_o !== exp_data || perr !== exp_perr) begin errors++; $display("FAIL rnd%0d_data got %h/%b want %h/%b", i, rdata_o, perr, exp_data, exp_perr); end
    end
  endtask

`ifdef NXU8_SIO_PARITY_EN
  task automatic test_parity();
    logic        w_t [3] = '{1'b0, 1'b0, 1'b1};
    logic        f_t [3] = '{1'b1, 1'b0, 1'b0};
    logic [6:0]  a_t [3] = '{7'h05, 7'h05, 7'h12};
    logic [15:0] d_t [3] = '{16'h0000, 16'h0000, 16'hA55A};
    logic [15:0] r_t [3] = '{16'h1234, 16'h8001, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      do_frame(w_t[i], a_t[i], d_t[i], r_t[i], f_t[i], 1'b0, 1'b0, 0);
      if (!w_t[i]) begin exp_data = r_t[i]; exp_perr = f_t[i]; end
      vectors++; if (timed_out || busy_cnt != exp_busy(w_t[i])) begin errors++; $display("FAIL par%0d_busy got %0d want %0d", i, busy_cnt, exp_busy(w_t[i])); end
      vectors++; if (nsmp != exp_slots(w_t[i]) || obs_v !== exp_stream(w_t[i], a_t[i], d_t[i], tbv)) begin errors++; $display("FAIL par%0d_stream got %h/%0d want %h", i, obs_v, nsmp, exp_stream(w_t[i], a_t[i], d_t[i], tbv)); end
      vectors++; if (rdata_o !== exp_data || perr !== exp_perr) begin errors++; $display("FAIL par%0d_perr got %h/%b want %h/%b", i, rdata_o, perr, exp_data, exp_perr); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef NXU8_SIO_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
